// File: rtl/ai_mst_wr_dispatcher_if.sv
// Write-path bundle between one AXI4 master port and the per-slave arbitration stages.
// The slave modport is the dispatcher's view; the master modport is the surrounding fabric's view.
interface ai_mst_wr_dispatcher_if #(
  parameter int SLV_AMT           = 2,
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int TRANS_WR_RESP_W   = 2
);
  logic [TRANS_MST_ID_W-1:0]            m_AWID_i;
  logic [ADDR_WIDTH-1:0]                m_AWADDR_i;
  logic [TRANS_BURST_W-1:0]             m_AWBURST_i;
  logic [TRANS_DATA_LEN_W-1:0]          m_AWLEN_i;
  logic [TRANS_DATA_SIZE_W-1:0]         m_AWSIZE_i;
  logic                                 m_AWVALID_i;
  logic                                 m_AWREADY_o;
  logic [DATA_WIDTH-1:0]                m_WDATA_i;
  logic                                 m_WLAST_i;
  logic                                 m_WVALID_i;
  logic                                 m_WREADY_o;
  logic [TRANS_MST_ID_W-1:0]            m_BID_o;
  logic [TRANS_WR_RESP_W-1:0]           m_BRESP_o;
  logic                                 m_BVALID_o;
  logic                                 m_BREADY_i;
  logic [TRANS_MST_ID_W-1:0]            sa_AWID_o;
  logic [ADDR_WIDTH-1:0]                sa_AWADDR_o;
  logic [TRANS_BURST_W-1:0]             sa_AWBURST_o;
  logic [TRANS_DATA_LEN_W-1:0]          sa_AWLEN_o;
  logic [TRANS_DATA_SIZE_W-1:0]         sa_AWSIZE_o;
  logic [SLV_AMT-1:0]                   sa_AWVALID_o;
  logic [SLV_AMT-1:0]                   sa_AWREADY_i;
  logic [SLV_AMT-1:0]                   sa_AW_outst_full_o;
  logic [DATA_WIDTH-1:0]                sa_WDATA_o;
  logic                                 sa_WLAST_o;
  logic [SLV_AMT-1:0]                   sa_WVALID_o;
  logic [SLV_AMT-1:0]                   sa_WREADY_i;
  logic [SLV_AMT-1:0]                   sa_slv_sel_o;
  logic [TRANS_MST_ID_W*SLV_AMT-1:0]    sa_BID_i;
  logic [TRANS_WR_RESP_W*SLV_AMT-1:0]   sa_BRESP_i;
  logic [SLV_AMT-1:0]                   sa_BVALID_i;
  logic [SLV_AMT-1:0]                   sa_BREADY_o;

  modport slave (
    input  m_AWID_i, m_AWADDR_i, m_AWBURST_i, m_AWLEN_i, m_AWSIZE_i, m_AWVALID_i,
    output m_AWREADY_o,
    input  m_WDATA_i, m_WLAST_i, m_WVALID_i,
    output m_WREADY_o,
    output m_BID_o, m_BRESP_o, m_BVALID_o,
    input  m_BREADY_i,
    output sa_AWID_o, sa_AWADDR_o, sa_AWBURST_o, sa_AWLEN_o, sa_AWSIZE_o, sa_AWVALID_o,
    input  sa_AWREADY_i,
    output sa_AW_outst_full_o,
    output sa_WDATA_o, sa_WLAST_o, sa_WVALID_o,
    input  sa_WREADY_i,
    output sa_slv_sel_o,
    input  sa_BID_i, sa_BRESP_i, sa_BVALID_i,
    output sa_BREADY_o
  );

  modport master (
    output m_AWID_i, m_AWADDR_i, m_AWBURST_i, m_AWLEN_i, m_AWSIZE_i, m_AWVALID_i,
    input  m_AWREADY_o,
    output m_WDATA_i, m_WLAST_i, m_WVALID_i,
    input  m_WREADY_o,
    input  m_BID_o, m_BRESP_o, m_BVALID_o,
    output m_BREADY_i,
    input  sa_AWID_o, sa_AWADDR_o, sa_AWBURST_o, sa_AWLEN_o, sa_AWSIZE_o, sa_AWVALID_o,
    output sa_AWREADY_i,
    input  sa_AW_outst_full_o,
    input  sa_WDATA_o, sa_WLAST_o, sa_WVALID_o,
    output sa_WREADY_i,
    input  sa_slv_sel_o,
    output sa_BID_i, sa_BRESP_i, sa_BVALID_i,
    input  sa_BREADY_o
  );
endinterface

// File: rtl/ai_mst_wr_dispatcher.sv
// Per-master write dispatcher: decodes AW to one slave, steers W by a queued target order, returns B.
// Zero-latency combinational paths; AW stalls on outstanding/order-queue full or a pending switch of slave.
module ai_mst_wr_dispatcher #(
  parameter int SLV_ID_MSB_IDX    = 30,
  parameter int SLV_ID_LSB_IDX    = 30,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int TRANS_WR_RESP_W   = 2
) (
  input logic                   ACLK_i,
  input logic                   ARESET_i,
  ai_mst_wr_dispatcher_if.slave bus
);
  localparam int SLV_W   = SLV_ID_MSB_IDX - SLV_ID_LSB_IDX + 1;
  localparam int SLV_AMT = 2 ** SLV_W;
  localparam int CNT_W   = $clog2(OUTSTANDING_AMT + 1);
  localparam int IDX_W   = $clog2(OUTSTANDING_AMT);
  localparam int PTR_W   = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTSTANDING_AMT);

  typedef struct packed {
    logic [TRANS_MST_ID_W-1:0]    id;
    logic [ADDR_WIDTH-1:0]        addr;
    logic [TRANS_BURST_W-1:0]     burst;
    logic [TRANS_DATA_LEN_W-1:0]  len;
    logic [TRANS_DATA_SIZE_W-1:0] size;
  } aw_hdr_t;

  aw_hdr_t                    aw_hdr;
  logic [DATA_WIDTH-1:0]      w_dat;
  logic [TRANS_WR_RESP_W-1:0] b_resp;

  logic [CNT_W-1:0] outst_cnt;
  logic [SLV_W-1:0] cur_slv;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [SLV_W-1:0] order_mem [OUTSTANDING_AMT];

  logic [SLV_W-1:0] aw_idx;
  logic [SLV_W-1:0] w_head;
  logic fifo_full, fifo_empty, cnt_full, cnt_busy, aw_stall;
  logic aw_hs, w_pop, b_hs;

  assign aw_hdr = '{id: bus.m_AWID_i, addr: bus.m_AWADDR_i, burst: bus.m_AWBURST_i,
                    len: bus.m_AWLEN_i, size: bus.m_AWSIZE_i};
  assign bus.sa_AWID_o    = aw_hdr.id;
  assign bus.sa_AWADDR_o  = aw_hdr.addr;
  assign bus.sa_AWBURST_o = aw_hdr.burst;
  assign bus.sa_AWLEN_o   = aw_hdr.len;
  assign bus.sa_AWSIZE_o  = aw_hdr.size;

  assign w_dat          = bus.m_WDATA_i;
  assign bus.sa_WDATA_o = w_dat;
  assign bus.sa_WLAST_o = bus.m_WLAST_i;

  assign aw_idx     = aw_hdr.addr[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];
  assign w_head     = order_mem[rd_ptr[IDX_W-1:0]];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                      (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign cnt_full   = (outst_cnt == CNT_MAX);
  assign cnt_busy   = (outst_cnt != '0);
  // Holding AW while another slave still owes responses keeps B returning in issue order.
  assign aw_stall   = cnt_full | fifo_full | (cnt_busy & (aw_idx != cur_slv));

  always_comb begin
    bus.sa_AWVALID_o       = '0;
    bus.sa_AW_outst_full_o = '0;
    bus.sa_slv_sel_o       = '0;
    bus.sa_BREADY_o        = '0;
    bus.m_AWREADY_o        = 1'b0;
    bus.m_WREADY_o         = 1'b0;
    bus.m_BVALID_o         = 1'b0;
    if (!ARESET_i) begin
      bus.sa_AWVALID_o[aw_idx]        = bus.m_AWVALID_i & ~aw_stall;
      bus.m_AWREADY_o                 = bus.sa_AWREADY_i[aw_idx] & ~aw_stall;
      bus.sa_AW_outst_full_o[cur_slv] = cnt_full;
      if (!fifo_empty) begin
        bus.sa_slv_sel_o[w_head] = 1'b1;
        bus.m_WREADY_o           = bus.sa_WREADY_i[w_head];
      end
      bus.m_BVALID_o           = bus.sa_BVALID_i[cur_slv] & cnt_busy;
      bus.sa_BREADY_o[cur_slv] = bus.m_BREADY_i & cnt_busy;
    end
  end

  assign bus.sa_WVALID_o = bus.sa_slv_sel_o & {SLV_AMT{bus.m_WVALID_i}};
  assign bus.m_BID_o     = bus.sa_BID_i[int'(cur_slv)*TRANS_MST_ID_W +: TRANS_MST_ID_W];
  assign b_resp          = bus.sa_BRESP_i[int'(cur_slv)*TRANS_WR_RESP_W +: TRANS_WR_RESP_W];
  assign bus.m_BRESP_o   = b_resp;

  assign aw_hs = bus.m_AWVALID_i & bus.m_AWREADY_o;
  assign w_pop = bus.m_WVALID_i & bus.m_WREADY_o & bus.m_WLAST_i;
  assign b_hs  = bus.m_BVALID_o & bus.m_BREADY_i;

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      outst_cnt <= '0;
      cur_slv   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (aw_hs) begin
        wr_ptr  <= wr_ptr + 1'b1;
        cur_slv <= aw_idx;
      end
      if (w_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (aw_hs && !b_hs) begin
        outst_cnt <= outst_cnt + 1'b1;
      end else if (b_hs && !aw_hs) begin
        outst_cnt <= outst_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (aw_hs) begin
      order_mem[wr_ptr[IDX_W-1:0]] <= aw_idx;
    end
  end
endmodule

// File: tb/tb_ai_mst_wr_dispatcher.sv
// Self-checking bench for ai_mst_wr_dispatcher: directed scenarios plus a randomized run
// against a queue-based model of target order, outstanding count and active slave.
module tb_ai_mst_wr_dispatcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ai_mst_wr_dispatcher_if #(.SLV_AMT(2)) bus ();

  ai_mst_wr_dispatcher dut (
    .ACLK_i   (clk),
    .ARESET_i (rst),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.m_AWID_i = '0; bus.m_AWADDR_i = '0; bus.m_AWBURST_i = 2'd1; bus.m_AWLEN_i = '0;
    bus.m_AWSIZE_i = 3'd2; bus.m_AWVALID_i = 1'b0; bus.m_WDATA_i = '0; bus.m_WLAST_i = 1'b0;
    bus.m_WVALID_i = 1'b0; bus.m_BREADY_i = 1'b0; bus.sa_AWREADY_i = '0; bus.sa_WREADY_i = '0;
    bus.sa_BID_i = '0; bus.sa_BRESP_i = '0; bus.sa_BVALID_i = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    checks++; if (bus.sa_AWVALID_o !== 2'b00) begin failures++; $display("FAIL rst_sa_awvalid got=%b exp=00", bus.sa_AWVALID_o); end
    checks++; if (bus.m_AWREADY_o !== 1'b0) begin failures++; $display("FAIL rst_awready got=%b exp=0", bus.m_AWREADY_o); end
    checks++; if (bus.sa_slv_sel_o !== 2'b00) begin failures++; $display("FAIL rst_slv_sel got=%b exp=00", bus.sa_slv_sel_o); end
    checks++; if (bus.sa_AW_outst_full_o !== 2'b00) begin failures++; $display("FAIL rst_outst_full got=%b exp=00", bus.sa_AW_outst_full_o); end
    // Offer every ready/valid from outside: an empty dispatcher must accept nothing on W or B.
    bus.sa_AWREADY_i = 2'b11; bus.m_WVALID_i = 1'b1; bus.sa_WREADY_i = 2'b11;
    bus.sa_BVALID_i = 2'b11; bus.m_BREADY_i = 1'b1;
    #1;
    checks++; if (bus.m_WREADY_o !== 1'b0) begin failures++; $display("FAIL rst_wready got=%b exp=0", bus.m_WREADY_o); end
    checks++; if (bus.sa_WVALID_o !== 2'b00) begin failures++; $display("FAIL rst_sa_wvalid got=%b exp=00", bus.sa_WVALID_o); end
    checks++; if (bus.m_BVALID_o !== 1'b0) begin failures++; $display("FAIL rst_bvalid got=%b exp=0", bus.m_BVALID_o); end
    checks++; if (bus.sa_BREADY_o !== 2'b00) begin failures++; $display("FAIL rst_sa_bready got=%b exp=00", bus.sa_BREADY_o); end
    tick();
    idle();
  endtask

  task automatic test_single_write();
    logic [4:0]  id;
    logic [31:0] dat;
    do_reset();
    id = 5'($urandom);
    bus.m_AWID_i = id; bus.m_AWADDR_i = 32'h4000_0000; bus.m_AWLEN_i = 3'd3;
    bus.m_AWVALID_i = 1'b1; bus.sa_AWREADY_i = 2'b10;
    #3;
    checks++; if (bus.sa_AWVALID_o !== 2'b10) begin failures++; $display("FAIL sw_sa_awvalid got=%b exp=10", bus.sa_AWVALID_o); end
    checks++; if (bus.m_AWREADY_o !== 1'b1) begin failures++; $display("FAIL sw_awready got=%b exp=1", bus.m_AWREADY_o); end
    checks++; if (bus.sa_AWID_o !== id) begin failures++; $display("FAIL sw_awid got=%h exp=%h", bus.sa_AWID_o, id); end
    checks++; if (bus.sa_AWADDR_o !== 32'h4000_0000) begin failures++; $display("FAIL sw_awaddr got=%h exp=40000000", bus.sa_AWADDR_o); end
    tick();
    bus.m_AWVALID_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      dat = $urandom;
      bus.m_WDATA_i = dat; bus.m_WVALID_i = 1'b1; bus.m_WLAST_i = (b == 3); bus.sa_WREADY_i = 2'b10;
      #3;
      checks++; if (bus.sa_slv_sel_o !== 2'b10) begin failures++; $display("FAIL sw_slv_sel beat=%0d got=%b exp=10", b, bus.sa_slv_sel_o); end
      checks++; if (bus.sa_WVALID_o !== 2'b10) begin failures++; $display("FAIL sw_sa_wvalid beat=%0d got=%b exp=10", b, bus.sa_WVALID_o); end
      checks++; if (bus.m_WREADY_o !== 1'b1) begin failures++; $display("FAIL sw_wready beat=%0d got=%b exp=1", b, bus.m_WREADY_o); end
      checks++; if (bus.sa_WDATA_o !== dat) begin failures++; $display("FAIL sw_wdata beat=%0d got=%h exp=%h", b, bus.sa_WDATA_o, dat); end
      tick();
    end
    #3;
    checks++; if (bus.m_WREADY_o !== 1'b0) begin failures++; $display("FAIL sw_fifo_drained_wready got=%b exp=0", bus.m_WREADY_o); end
    checks++; if (bus.sa_slv_sel_o !== 2'b00) begin failures++; $display("FAIL sw_fifo_drained_sel got=%b exp=00", bus.sa_slv_sel_o); end
    bus.m_WVALID_i = 1'b0; bus.m_WLAST_i = 1'b0;
    bus.sa_BVALID_i = 2'b11; bus.sa_BID_i = {id, ~id}; bus.sa_BRESP_i = 4'b0011; bus.m_BREADY_i = 1'b1;
    #1;
    checks++; if (bus.m_BVALID_o !== 1'b1) begin failures++; $display("FAIL sw_bvalid got=%b exp=1", bus.m_BVALID_o); end
    checks++; if (bus.m_BID_o !== id) begin failures++; $display("FAIL sw_bid got=%h exp=%h", bus.m_BID_o, id); end
    checks++; if (bus.m_BRESP_o !== 2'b00) begin failures++; $display("FAIL sw_bresp got=%b exp=00", bus.m_BRESP_o); end
    checks++; if (bus.sa_BREADY_o !== 2'b10) begin failures++; $display("FAIL sw_sa_bready got=%b exp=10", bus.sa_BREADY_o); end
    tick();
    #3;
    checks++; if (bus.m_BVALID_o !== 1'b0) begin failures++; $display("FAIL sw_cnt_zero_bvalid got=%b exp=0", bus.m_BVALID_o); end
    checks++; if (bus.sa_BREADY_o !== 2'b00) begin failures++; $display("FAIL sw_cnt_zero_bready got=%b exp=00", bus.sa_BREADY_o); end
    idle();
  endtask

  task automatic test_slave_switch();
    do_reset();
    bus.m_AWADDR_i = 32'h0000_0100; bus.m_AWVALID_i = 1'b1; bus.sa_AWREADY_i = 2'b11;
    for (int k = 0; k < 2; k++) begin
      #3;
      checks++; if (bus.m_AWREADY_o !== 1'b1) begin failures++; $display("FAIL ss_aw0_ready n=%0d got=%b exp=1", k, bus.m_AWREADY_o); end
      tick();
    end
    bus.m_AWADDR_i = 32'h4000_0100;
    #3;
    checks++; if (bus.m_AWREADY_o !== 1'b0) begin failures++; $display("FAIL ss_switch_stall got=%b exp=0", bus.m_AWREADY_o); end
    checks++; if (bus.sa_AWVALID_o !== 2'b00) begin failures++; $display("FAIL ss_switch_sa_awvalid got=%b exp=00", bus.sa_AWVALID_o); end
    tick();
    bus.sa_BVALID_i = 2'b01; bus.m_BREADY_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #3;
      checks++; if (bus.m_AWREADY_o !== 1'b0) begin failures++; $display("FAIL ss_stall_during_b n=%0d got=%b exp=0", k, bus.m_AWREADY_o); end
      checks++; if (bus.m_BVALID_o !== 1'b1) begin failures++; $display("FAIL ss_b0_valid n=%0d got=%b exp=1", k, bus.m_BVALID_o); end
      tick();
    end
    bus.sa_BVALID_i = 2'b00; bus.m_BREADY_i = 1'b0;
    #3;
    checks++; if (bus.m_AWREADY_o !== 1'b1) begin failures++; $display("FAIL ss_switch_accept got=%b exp=1", bus.m_AWREADY_o); end
    checks++; if (bus.sa_AWVALID_o !== 2'b10) begin failures++; $display("FAIL ss_switch_sa_awvalid1 got=%b exp=10", bus.sa_AWVALID_o); end
    tick();
    idle();
  endtask

  task automatic test_outstanding_full();
    do_reset();
    bus.m_AWADDR_i = 32'h0000_1000; bus.m_AWVALID_i = 1'b1; bus.sa_AWREADY_i = 2'b01;
    for (int k = 0; k < 8; k++) begin
      #3;
      checks++; if (bus.m_AWREADY_o !== 1'b1) begin failures++; $display("FAIL of_fill n=%0d got=%b exp=1", k, bus.m_AWREADY_o); end
      tick();
    end
    #3;
    checks++; if (bus.m_AWREADY_o !== 1'b0) begin failures++; $display("FAIL of_ninth_stall got=%b exp=0", bus.m_AWREADY_o); end
    checks++; if (bus.sa_AWVALID_o !== 2'b00) begin failures++; $display("FAIL of_ninth_sa_awvalid got=%b exp=00", bus.sa_AWVALID_o); end
    checks++; if (bus.sa_AW_outst_full_o !== 2'b01) begin failures++; $display("FAIL of_full_flag got=%b exp=01", bus.sa_AW_outst_full_o); end
    tick();
    bus.m_WVALID_i = 1'b1; bus.m_WLAST_i = 1'b1; bus.sa_WREADY_i = 2'b01;
    bus.sa_BVALID_i = 2'b01; bus.m_BREADY_i = 1'b1;
    #3;
    checks++; if (bus.m_WREADY_o !== 1'b1) begin failures++; $display("FAIL of_w_pop got=%b exp=1", bus.m_WREADY_o); end
    checks++; if (bus.m_BVALID_o !== 1'b1) begin failures++; $display("FAIL of_b_valid got=%b exp=1", bus.m_BVALID_o); end
    checks++; if (bus.m_AWREADY_o !== 1'b0) begin failures++; $display("FAIL of_pop_no_same_cycle got=%b exp=0", bus.m_AWREADY_o); end
    tick();
    bus.m_WVALID_i = 1'b0; bus.m_WLAST_i = 1'b0; bus.sa_BVALID_i = 2'b00; bus.m_BREADY_i = 1'b0;
    #3;
    checks++; if (bus.sa_AW_outst_full_o !== 2'b00) begin failures++; $display("FAIL of_flag_clear got=%b exp=00", bus.sa_AW_outst_full_o); end
    checks++; if (bus.m_AWREADY_o !== 1'b1) begin failures++; $display("FAIL of_ninth_accept got=%b exp=1", bus.m_AWREADY_o); end
    tick();
    #3;
    checks++; if (bus.sa_AW_outst_full_o !== 2'b01) begin failures++; $display("FAIL of_refull_flag got=%b exp=01", bus.sa_AW_outst_full_o); end
    idle();
  endtask

  task automatic test_w_before_aw();
    do_reset();
    bus.m_WVALID_i = 1'b1; bus.m_WLAST_i = 1'b1; bus.m_WDATA_i = 32'hA5A5_0001; bus.sa_WREADY_i = 2'b11;
    for (int k = 0; k < 2; k++) begin
      #3;
      checks++; if (bus.m_WREADY_o !== 1'b0) begin failures++; $display("FAIL wb_held n=%0d got=%b exp=0", k, bus.m_WREADY_o); end
      checks++; if (bus.sa_WVALID_o !== 2'b00) begin failures++; $display("FAIL wb_sa_wvalid n=%0d got=%b exp=00", k, bus.sa_WVALID_o); end
      tick();
    end
    bus.m_AWADDR_i = 32'h4000_0040; bus.m_AWVALID_i = 1'b1; bus.sa_AWREADY_i = 2'b10;
    #3;
    checks++; if (bus.m_WREADY_o !== 1'b0) begin failures++; $display("FAIL wb_aw_cycle got=%b exp=0", bus.m_WREADY_o); end
    tick();
    bus.m_AWVALID_i = 1'b0;
    #3;
    checks++; if (bus.m_WREADY_o !== 1'b1) begin failures++; $display("FAIL wb_routed_ready got=%b exp=1", bus.m_WREADY_o); end
    checks++; if (bus.sa_WVALID_o !== 2'b10) begin failures++; $display("FAIL wb_routed_sa_wvalid got=%b exp=10", bus.sa_WVALID_o); end
    tick();
    #3;
    checks++; if (bus.m_WREADY_o !== 1'b0) begin failures++; $display("FAIL wb_after_pop got=%b exp=0", bus.m_WREADY_o); end
    idle();
  endtask

  task automatic test_aw_b_same_cycle();
    do_reset();
    bus.m_AWADDR_i = 32'h0000_0200; bus.m_AWVALID_i = 1'b1; bus.sa_AWREADY_i = 2'b01;
    for (int k = 0; k < 3; k++) tick();
    bus.sa_BVALID_i = 2'b01; bus.m_BREADY_i = 1'b1;
    #3;
    checks++; if (bus.m_AWREADY_o !== 1'b1) begin failures++; $display("FAIL ab_aw_ready got=%b exp=1", bus.m_AWREADY_o); end
    checks++; if (bus.m_BVALID_o !== 1'b1) begin failures++; $display("FAIL ab_b_valid got=%b exp=1", bus.m_BVALID_o); end
    tick();
    bus.m_AWVALID_i = 1'b0;
    // Exactly three more responses must be taken before the count drains to zero.
    for (int k = 0; k < 3; k++) begin
      #3;
      checks++; if (bus.m_BVALID_o !== 1'b1) begin failures++; $display("FAIL ab_drain n=%0d got=%b exp=1", k, bus.m_BVALID_o); end
      tick();
    end
    #3;
    checks++; if (bus.m_BVALID_o !== 1'b0) begin failures++; $display("FAIL ab_drained_bvalid got=%b exp=0", bus.m_BVALID_o); end
    checks++; if (bus.sa_BREADY_o !== 2'b00) begin failures++; $display("FAIL ab_drained_bready got=%b exp=00", bus.sa_BREADY_o); end
    idle();
    bus.m_AWADDR_i = 32'h4000_0000; bus.m_AWVALID_i = 1'b1; bus.sa_AWREADY_i = 2'b10;
    tick();
    idle();
    bus.m_WVALID_i = 1'b1; bus.m_WLAST_i = 1'b0; bus.sa_WREADY_i = 2'b11;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.sa_BVALID_i = 2'b11; bus.m_BREADY_i = 1'b1;
    bus.m_AWADDR_i = 32'h0000_0000; bus.m_AWVALID_i = 1'b1; bus.sa_AWREADY_i = 2'b01;
    #3;
    checks++; if (bus.m_WREADY_o !== 1'b0) begin failures++; $display("FAIL mr_wready got=%b exp=0", bus.m_WREADY_o); end
    checks++; if (bus.sa_slv_sel_o !== 2'b00) begin failures++; $display("FAIL mr_slv_sel got=%b exp=00", bus.sa_slv_sel_o); end
    checks++; if (bus.m_BVALID_o !== 1'b0) begin failures++; $display("FAIL mr_bvalid got=%b exp=0", bus.m_BVALID_o); end
    checks++; if (bus.m_AWREADY_o !== 1'b1) begin failures++; $display("FAIL mr_aw_other_slave got=%b exp=1", bus.m_AWREADY_o); end
    tick();
    idle();
  endtask

  task automatic test_random();
    int         cnt;
    int         cur;
    int         wq[$];
    int         idx;
    int         head;
    bit         stall;
    bit         aw_hs;
    bit         w_pop;
    bit         b_hs;
    logic [1:0] e_awvld, e_sel, e_wvld, e_brdy, e_full;
    logic       e_awrdy, e_wrdy, e_bvld;
    logic [9:0] bid_vec;
    logic [3:0] bresp_vec;
    int         b_pct[4] = '{10, 35, 70, 4};
    do_reset();
    cnt = 0; cur = 0; wq.delete();
    for (int ph = 0; ph < 4; ph++) begin
      for (int cyc = 0; cyc < 600; cyc++) begin
        bid_vec = 10'($urandom); bresp_vec = 4'($urandom);
        bus.m_AWID_i = 5'($urandom); bus.m_AWADDR_i = $urandom; bus.m_AWLEN_i = 3'($urandom);
        bus.m_AWVALID_i = ($urandom_range(0, 99) < 60); bus.sa_AWREADY_i = 2'($urandom_range(0, 3));
        bus.m_WDATA_i = $urandom; bus.m_WVALID_i = ($urandom_range(0, 99) < 70);
        bus.m_WLAST_i = ($urandom_range(0, 2) == 0); bus.sa_WREADY_i = 2'($urandom_range(0, 3));
        bus.sa_BVALID_i = {($urandom_range(0, 99) < b_pct[ph]), ($urandom_range(0, 99) < b_pct[ph])};
        bus.sa_BID_i = bid_vec; bus.sa_BRESP_i = bresp_vec; bus.m_BREADY_i = ($urandom_range(0, 99) < 70);
        #3;
        idx   = int'(bus.m_AWADDR_i[30]);
        stall = (cnt == 8) || (wq.size() == 8) || (cnt != 0 && idx != cur);
        e_awrdy = bus.sa_AWREADY_i[idx] && !stall;
        e_awvld = (bus.m_AWVALID_i && !stall) ? 2'(1 << idx) : 2'b00;
        if (wq.size() == 0) begin
          e_sel = 2'b00; e_wrdy = 1'b0;
        end else begin
          head = wq[0]; e_sel = 2'(1 << head); e_wrdy = bus.sa_WREADY_i[head];
        end
        e_wvld = bus.m_WVALID_i ? e_sel : 2'b00;
        e_bvld = bus.sa_BVALID_i[cur] && (cnt != 0);
        e_brdy = (bus.m_BREADY_i && cnt != 0) ? 2'(1 << cur) : 2'b00;
        e_full = (cnt == 8) ? 2'(1 << cur) : 2'b00;
        checks++; if (bus.m_AWREADY_o !== e_awrdy) begin failures++; $display("FAIL rnd_awready cyc=%0d got=%b exp=%b", cyc, bus.m_AWREADY_o, e_awrdy); end
        checks++; if (bus.sa_AWVALID_o !== e_awvld) begin failures++; $display("FAIL rnd_sa_awvalid cyc=%0d got=%b exp=%b", cyc, bus.sa_AWVALID_o, e_awvld); end
        checks++; if (bus.sa_slv_sel_o !== e_sel) begin failures++; $display("FAIL rnd_slv_sel cyc=%0d got=%b exp=%b", cyc, bus.sa_slv_sel_o, e_sel); end
        checks++; if (bus.sa_WVALID_o !== e_wvld) begin failures++; $display("FAIL rnd_sa_wvalid cyc=%0d got=%b exp=%b", cyc, bus.sa_WVALID_o, e_wvld); end
        checks++; if (bus.m_WREADY_o !== e_wrdy) begin failures++; $display("FAIL rnd_wready cyc=%0d got=%b exp=%b", cyc, bus.m_WREADY_o, e_wrdy); end
        checks++; if (bus.m_BVALID_o !== e_bvld) begin failures++; $display("FAIL rnd_bvalid cyc=%0d got=%b exp=%b", cyc, bus.m_BVALID_o, e_bvld); end
        checks++; if (bus.sa_BREADY_o !== e_brdy) begin failures++; $display("FAIL rnd_sa_bready cyc=%0d got=%b exp=%b", cyc, bus.sa_BREADY_o, e_brdy); end
        checks++; if (bus.sa_AW_outst_full_o !== e_full) begin failures++; $display("FAIL rnd_outst_full cyc=%0d got=%b exp=%b", cyc, bus.sa_AW_outst_full_o, e_full); end
        if (e_bvld) begin
          checks++; if (bus.m_BID_o !== bid_vec[cur*5 +: 5]) begin failures++; $display("FAIL rnd_bid cyc=%0d got=%h exp=%h", cyc, bus.m_BID_o, bid_vec[cur*5 +: 5]); end
          checks++; if (bus.m_BRESP_o !== bresp_vec[cur*2 +: 2]) begin failures++; $display("FAIL rnd_bresp cyc=%0d got=%b exp=%b", cyc, bus.m_BRESP_o, bresp_vec[cur*2 +: 2]); end
        end
        aw_hs = bus.m_AWVALID_i && e_awrdy;
        w_pop = bus.m_WVALID_i && e_wrdy && bus.m_WLAST_i;
        b_hs  = e_bvld && bus.m_BREADY_i;
        if (w_pop) void'(wq.pop_front());
        if (aw_hs) begin
          wq.push_back(idx);
          cur = idx;
        end
        cnt = cnt + int'(aw_hs) - int'(b_hs);
        tick();
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_slave_switch();
    test_outstanding_full();
    test_w_before_aw();
    test_aw_b_same_cycle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ai_mst_wr_dispatcher.md
Name: ai_mst_wr_dispatcher

Overview:
- Per-master write-path dispatcher. Sits between one AXI4 master port and the per-slave arbitration stages.
- Decodes AWADDR to a target slave and broadcasts AW to that slave's arbitration stage.
- Queues the target order so W beats are steered to the correct slave with a one-hot slave-select.
- Returns B responses from the active slave and tracks outstanding writes. Only one target slave may have writes in flight at a time, which preserves AXI response ordering.

Parameters:
- SLV_ID_MSB_IDX, 30, MSB of slave-select field in AWADDR
- SLV_ID_LSB_IDX, 30, LSB of slave-select field; SLV_AMT = 2**(MSB-LSB+1)
- OUTSTANDING_AMT, 8, max in-flight writes, also W-order FIFO depth (power of 2)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TRANS_MST_ID_W, 5, AxID width
- TRANS_BURST_W, 2, AWBURST width
- TRANS_DATA_LEN_W, 3, AWLEN width
- TRANS_DATA_SIZE_W, 3, AWSIZE width
- TRANS_WR_RESP_W, 2, BRESP width

Ports:
- ACLK_i  in  1  clock; all logic on rising edge
- ARESET_i  in  1  reset, synchronous, active-high
- m_AWID_i / m_AWADDR_i / m_AWBURST_i / m_AWLEN_i / m_AWSIZE_i  in  param widths  master AW payload
- m_AWVALID_i  in  1 ; m_AWREADY_o  out  1  AW handshake
- m_WDATA_i  in  DATA_WIDTH ; m_WLAST_i, m_WVALID_i  in  1 ; m_WREADY_o  out  1
- m_BID_o  out  TRANS_MST_ID_W ; m_BRESP_o  out  TRANS_WR_RESP_W ; m_BVALID_o  out  1 ; m_BREADY_i  in  1
- sa_AWID_o / sa_AWADDR_o / sa_AWBURST_o / sa_AWLEN_o / sa_AWSIZE_o  out  param widths  AW payload broadcast to all slaves
- sa_AWVALID_o  out  SLV_AMT ; sa_AWREADY_i  in  SLV_AMT  per-slave AW handshake
- sa_AW_outst_full_o  out  SLV_AMT  per-slave outstanding-full flag
- sa_WDATA_o  out  DATA_WIDTH ; sa_WLAST_o  out  1  W broadcast
- sa_WVALID_o  out  SLV_AMT ; sa_WREADY_i  in  SLV_AMT
- sa_slv_sel_o  out  SLV_AMT  one-hot W owner
- sa_BID_i  in  TRANS_MST_ID_W*SLV_AMT ; sa_BRESP_i  in  TRANS_WR_RESP_W*SLV_AMT ; sa_BVALID_i  in  SLV_AMT ; sa_BREADY_o  out  SLV_AMT

Behaviour:
- Reset (synchronous, ARESET_i=1 at edge):
  - outst_cnt=0, cur_slv=0, FIFO wr/rd pointers=0 (empty).
  - Outputs: all *VALID_o=0, m_AWREADY_o=0, m_WREADY_o=0, sa_BREADY_o=0, sa_slv_sel_o=0, sa_AW_outst_full_o=0.
  - Reset mid-burst drops all state; no handshakes complete during reset.
- Decode: idx = m_AWADDR_i[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX].
- AW channel:
  - Payload passes through combinationally; zero latency.
  - aw_stall = (outst_cnt==OUTSTANDING_AMT) | fifo_full | (outst_cnt!=0 & idx!=cur_slv).
  - sa_AWVALID_o[idx] = m_AWVALID_i & ~aw_stall; other bits 0.
  - m_AWREADY_o = sa_AWREADY_i[idx] & ~aw_stall.
  - On AW handshake: push idx into the W-order FIFO, cur_slv<=idx, outst_cnt increments.
- sa_AW_outst_full_o[s] = (outst_cnt==OUTSTANDING_AMT) & (s==cur_slv).
- W channel:
  - head = FIFO read entry.
  - FIFO empty: m_WREADY_o=0, sa_WVALID_o=0, sa_slv_sel_o=0. W before its AW is held, not accepted.
  - FIFO non-empty: sa_slv_sel_o=onehot(head), sa_WVALID_o[head]=m_WVALID_i, m_WREADY_o=sa_WREADY_i[head].
  - W handshake with m_WLAST_i=1 pops the FIFO; the next beat routes to the new head in the following cycle.
  - Same-cycle push and pop are both performed. fifo_full is registered-count based; a pop does not unblock a push in the same cycle.
- B channel:
  - m_BVALID_o = sa_BVALID_i[cur_slv] & (outst_cnt!=0); BID/BRESP muxed from cur_slv.
  - sa_BREADY_o[cur_slv] = m_BREADY_i & (outst_cnt!=0); other bits 0.
  - B handshake decrements outst_cnt. AW and B handshakes in the same cycle leave outst_cnt unchanged.
  - With outst_cnt==0, stray B from any slave is not acknowledged.
- Widths:
  - outst_cnt is $clog2(OUTSTANDING_AMT+1) bits and never over- or underflows (guarded as above).
  - FIFO pointers are $clog2(OUTSTANDING_AMT)+1 bits with a wrap bit; full = MSBs differ and LSBs equal.

Test Plan:
- Reset, then idle → all VALID/READY outputs 0, sa_slv_sel_o=0.
- AW addr=0x4000_0000 (idx=1), sa_AWREADY_i=2'b10 → sa_AWVALID_o=2'b10, handshake in 1 cycle, outst_cnt=1. Then 4 W beats (AWLEN=3) → sa_slv_sel_o=2'b10 throughout, FIFO empty after WLAST. Then B from slave 1, BRESP=0 → m_BVALID_o=1, outst_cnt=0.
- Two AWs to slave 0 accepted, then AW to slave 1 → m_AWREADY_o=0 until both slave-0 Bs handshake, then accepted the next cycle.
- 8 AWs to slave 0 with no B → 9th stalled, sa_AW_outst_full_o=2'b01. One B returned → flag clears, 9th accepted.
- W beat presented before any AW → m_WREADY_o=0 until the AW handshakes; the beat is then routed.
- AW handshake and B handshake in the same cycle at outst_cnt=3 → outst_cnt remains 3. Assert ARESET_i mid-burst → next cycle FIFO empty, outst_cnt=0.
